// File: rtl/rr_arb16_ctrl_pkg.sv
// arb16_pkg: shared constants, FSM state type and a lowest-set-bit helper
// for the 16-way round-robin arbiter (rr_arb16_ctrl).
package arb16_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Isolates the lowest set bit of v (two's-complement trick); 0 if v == 0.
  function automatic logic [N_REQ-1:0] lowest_set(input logic [N_REQ-1:0] v);
    return v & (~v + N_REQ'(1));
  endfunction
endpackage

// File: rtl/rr_arb16_ctrl_if.sv
// rr_arb16_ctrl_if: request/grant bundle of the 16-way arbiter.
//   enable, req, done           : requester side -> arbiter
//   gnt, gnt_bin, gnt_valid,
//   timeout                     : arbiter -> requester side
// modport master = requester/testbench side, slave = arbiter side.
interface rr_arb16_ctrl_if;
  import arb16_pkg::*;

  logic              enable;
  logic [N_REQ-1:0]  req;
  logic              done;
  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_bin;
  logic              gnt_valid;
  logic              timeout;

  modport master (
    output enable, req, done,
    input  gnt, gnt_bin, gnt_valid, timeout
  );

  modport slave (
    input  enable, req, done,
    output gnt, gnt_bin, gnt_valid, timeout
  );
endinterface

// File: rtl/onehot16_to_bin.sv
// onehot16_to_bin: combinational one-hot to binary index encoder.
//   onehot_i : 16-bit one-hot vector
//   en_i     : when low the index is forced to 0
//   idx_o    : 4-bit index of the set bit
module onehot16_to_bin
  import arb16_pkg::*;
(
  input  logic [N_REQ-1:0] onehot_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o
);

  // OR of the indices of all set bits; exact for a one-hot input.
  always_comb begin
    idx_o = '0;
    if (en_i) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (onehot_i[i]) idx_o = idx_o | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arb16_ctrl.sv
// rr_arb16_ctrl: 16-requester round-robin arbiter, non-preemptive.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   bus       : rr_arb16_ctrl_if.slave
//     enable  : allow new grants
//     req     : level request lines
//     done    : release strobe from the grant holder
//     gnt     : registered one-hot grant
//     gnt_bin : index of gnt bit, 0 when idle
//     gnt_valid : gnt != 0
//     timeout : one-cycle pulse on forced release
// Optional macro ARB16_TIMEOUT_EN adds an 8-bit hold counter that forces a
// release after TIMEOUT_CYCLES grant cycles; without it timeout is tied 0.
module rr_arb16_ctrl
  import arb16_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              reset,
  rr_arb16_ctrl_if.slave   bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rr_arb16_ctrl: TIMEOUT_CYCLES must be in 2..255");
  end

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [N_REQ-1:0]  gnt_q;
  logic              gnt_valid_q;
  logic [IDX_W-1:0]  gnt_bin;

  logic [N_REQ-1:0]  mask;
  logic [N_REQ-1:0]  req_m;
  logic [N_REQ-1:0]  gnt_d;
  logic [IDX_W-1:0]  ptr_d;
  logic              rel_norm;
  logic              to_hit;
  logic              rel_d;

`ifdef ARB16_TIMEOUT_EN
  logic [7:0]        cnt_q;
  logic              timeout_q;
`endif

  onehot16_to_bin u_enc (
    .onehot_i (gnt_q),
    .en_i     (gnt_valid_q),
    .idx_o    (gnt_bin)
  );

  // Round-robin pick: lowest request at/above ptr, else wrap to the lowest
  // request overall.
  always_comb begin
    mask  = ~((N_REQ'(1) << ptr_q) - N_REQ'(1));
    req_m = bus.req & mask;
    gnt_d = (req_m != '0) ? lowest_set(req_m) : lowest_set(bus.req);
    // 4-bit add wraps 15 -> 0 on its own.
    ptr_d = gnt_bin + IDX_W'(1);
  end

  always_comb begin
    rel_norm = bus.done | ~bus.req[gnt_bin];
`ifdef ARB16_TIMEOUT_EN
    to_hit   = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    to_hit   = 1'b0;
`endif
    rel_d    = rel_norm | to_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
`ifdef ARB16_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef ARB16_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.enable && (bus.req != '0)) begin
            state_q     <= GRANT;
            gnt_q       <= gnt_d;
            gnt_valid_q <= 1'b1;
`ifdef ARB16_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        GRANT: begin
          // Release always wins over new requests; re-arbitration happens
          // in the IDLE cycle that follows, using the updated ptr.
          if (rel_d) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
`ifdef ARB16_TIMEOUT_EN
            timeout_q   <= ~rel_norm;
`endif
          end
`ifdef ARB16_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_bin   = gnt_bin;
  assign bus.gnt_valid = gnt_valid_q;
`ifdef ARB16_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb16_ctrl.sv
// tb_rr_arb16_ctrl: directed self-checking bench for rr_arb16_ctrl.
// A behavioural model (holder index + pointer, circular search) predicts the
// outputs every cycle; literal checks pin the model on directed sequences.
// Honours ARB16_TIMEOUT_EN (TIMEOUT_CYCLES=4 in that build).
module tb_rr_arb16_ctrl;

`ifdef ARB16_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_arb16_ctrl_if bus();

  rr_arb16_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the grant, where the search starts.
  int holder = -1;
  int ptr = 0;
  int hc = 0;
  logic exp_to = 1'b0;
  logic [15:0] exp_gnt;
  assign exp_gnt = (holder < 0) ? 16'h0 : (16'(1) << holder);

  always @(posedge clk) begin
    exp_to = 1'b0;
    if (reset) begin
      holder = -1; ptr = 0; hc = 0;
    end else if (holder < 0) begin
      if (bus.enable && bus.req != 16'h0) begin
        for (int k = 0; k < 16; k++) begin
          if (holder < 0 && bus.req[(ptr + k) % 16]) holder = (ptr + k) % 16;
        end
        hc = 0;
      end
    end else begin
      if (bus.done || !bus.req[holder]) begin
        ptr = (holder + 1) % 16; holder = -1;
      end
`ifdef ARB16_TIMEOUT_EN
      else if (hc == TO - 1) begin
        ptr = (holder + 1) % 16; holder = -1; exp_to = 1'b1;
      end else begin
        hc++;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
      chk("gnt_bin", 32'(bus.gnt_bin), (holder < 0) ? 32'd0 : 32'(holder));
      chk("gnt_valid", 32'(bus.gnt_valid), 32'(holder >= 0));
      chk("timeout", 32'(bus.timeout), 32'(exp_to));
      chk("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.req = 16'h0; bus.done = 1'b0;
    cyc(2);
    started = 1'b1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_valid", 32'(bus.gnt_valid), 32'd0);
    chk("rst_bin", 32'(bus.gnt_bin), 32'd0);
    chk("rst_to", 32'(bus.timeout), 32'd0);

    // No requests: nothing granted.
    reset = 1'b0; bus.enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("idle_valid", 32'(bus.gnt_valid), 32'd0);
    end

    // Two requesters alternate 0,15,0,15.
    bus.req = 16'h8001;
    cyc(1);
    chk("alt_bin0", 32'(bus.gnt_bin), 32'd0);
    for (int k = 0; k < 3; k++) begin
      bus.done = 1'b1; cyc(1);
      chk("alt_rel", 32'(bus.gnt_valid), 32'd0);
      bus.done = 1'b0; cyc(1);
      chk("alt_bin", 32'(bus.gnt_bin), (k % 2 == 0) ? 32'd15 : 32'd0);
    end
    bus.done = 1'b1; cyc(1);
    bus.done = 1'b0; bus.req = 16'h0; cyc(1);

    // All request: full rotation with wrap.
    bus.req = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      cyc(1);
      chk("rot_bin", 32'(bus.gnt_bin), 32'(i % 16));
      bus.done = 1'b1; cyc(1);
      bus.done = 1'b0;
    end
    bus.req = 16'h0; cyc(1);

    // Hold on 3 through enable low; no new grant while disabled.
    bus.req = 16'h0008; cyc(1);
    chk("en_bin3", 32'(bus.gnt_bin), 32'd3);
    bus.enable = 1'b0; bus.req = 16'h00F8;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("en_hold", 32'(bus.gnt_bin), 32'd3);
    end
    bus.done = 1'b1; cyc(1);
    chk("en_rel", 32'(bus.gnt_valid), 32'd0);
    bus.done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("en_off", 32'(bus.gnt_valid), 32'd0);
    end
    bus.enable = 1'b1; cyc(1);
    chk("en_bin4", 32'(bus.gnt_bin), 32'd4);
    bus.req = 16'h0; cyc(1);
    chk("reqdrop_rel", 32'(bus.gnt_valid), 32'd0);
    cyc(1);

    // Long hold on 5.
    bus.req = 16'h0020; cyc(1);
    chk("hold_bin5", 32'(bus.gnt_bin), 32'd5);
`ifdef ARB16_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("to_hold", 32'(bus.gnt_valid), 32'd1);
    end
    cyc(1);
    chk("to_rel", 32'(bus.gnt_valid), 32'd0);
    chk("to_pulse", 32'(bus.timeout), 32'd1);
    cyc(1);
    chk("to_regnt", 32'(bus.gnt_bin), 32'd5);
    chk("to_low", 32'(bus.timeout), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("nto_hold", 32'(bus.gnt_bin), 32'd5);
    end
`endif
    bus.req = 16'h0; cyc(2);

    // Reset mid-grant on 9; ptr must go back to 0.
    bus.req = 16'h0200; cyc(1);
    chk("rs_bin9", 32'(bus.gnt_bin), 32'd9);
    reset = 1'b1; cyc(1);
    chk("rs_gnt", 32'(bus.gnt), 32'd0);
    chk("rs_to", 32'(bus.timeout), 32'd0);
    reset = 1'b0; bus.req = 16'h0201; cyc(1);
    chk("rs_bin0", 32'(bus.gnt_bin), 32'd0);
    bus.done = 1'b1; cyc(1);

    // done held into IDLE is ignored; next grant from ptr=1 is 2.
    bus.req = 16'h0004; cyc(1);
    chk("idone_bin2", 32'(bus.gnt_bin), 32'd2);
    cyc(1);
    chk("idone_rel", 32'(bus.gnt_valid), 32'd0);
    bus.done = 1'b0; bus.req = 16'h0; cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
